mdu: RTL and testbench
======================

MDU -- requirements
Module: mdu

Interface
REQ-001 Parameter WIDTH, default 32, SHALL set operand, HI and LO width; legal values are even and at least 8.
REQ-002 Port clk  in  1 SHALL be the single clock; all state changes on its rising edge.
REQ-003 Port rst  in  1 SHALL be the reset, synchronous and active-high.
REQ-004 Port start  in  1 SHALL request an operation; sampled only when the unit is accepting.
REQ-005 Port op  in  2 SHALL select the operation: 00 mult (signed), 01 multu, 10 div (signed), 11 divu.
REQ-006 Port opr1  in  WIDTH SHALL be the multiplicand or dividend.
REQ-007 Port opr2  in  WIDTH SHALL be the multiplier or divisor.
REQ-008 Port flush  in  1 SHALL abort any operation in progress (pipeline exception or branch flush).
REQ-009 Port busy  out  1 SHALL be high while an operation is iterating.
REQ-010 Port done  out  1 SHALL pulse high for one cycle when a result is written.
REQ-011 Port hi  out  WIDTH SHALL hold the product high half or the remainder.
REQ-012 Port lo  out  WIDTH SHALL hold the product low half or the quotient.

Function
REQ-013 FSM states SHALL be IDLE, CALC and DONE; IDLE and DONE accept start.
REQ-014 Accepted start in cycle N SHALL latch op and operand magnitudes, and record sign flags for signed ops: operand signs; result sign = s1^s2; remainder sign = s1.
REQ-015 CALC SHALL run exactly WIDTH iterations (cycles N+1..N+WIDTH), with busy=1 and done=0 in each.
REQ-016 Multiply SHALL be radix-2 shift-add over magnitudes into a 2*WIDTH accumulator; signed results SHALL be two's-complement negated when s1^s2=1.
REQ-017 Divide SHALL be restoring, one quotient bit per cycle over magnitudes; signed quotient negated if s1^s2=1; signed remainder negated if s1=1.
REQ-018 In cycle N+WIDTH+1 the FSM SHALL be in DONE with done=1 and busy=0, and hi/lo SHALL carry the new result; latency is WIDTH+1 cycles from start to done.
REQ-019 hi/lo SHALL hold their last result until the next done; they SHALL never show partial values.
REQ-020 DONE SHALL go to IDLE, or to CALC if start=1 in that cycle (back-to-back operation, no bubble).
REQ-021 start while in CALC SHALL be ignored, with no queuing.
REQ-022 Divide by zero SHALL take full latency and give lo = all ones and hi = opr1, for both div and divu; no trap.
REQ-023 Signed div of most-negative by -1 SHALL give lo = most-negative (wrap) and hi = 0.
REQ-024 flush=1 in any state SHALL force IDLE next cycle with busy=0 and done=0; hi/lo unchanged; no done is issued for the aborted operation.
REQ-025 If flush and start are both high in the same cycle, flush SHALL win and start is dropped.
REQ-026 The iteration counter SHALL be ceil(log2(WIDTH+1)) bits and SHALL not wrap within an operation.

Reset
REQ-027 rst=1 SHALL, at the next edge, force IDLE, busy=0, done=0, hi=0, lo=0 and clear the counter and accumulators, including mid-operation.
REQ-028 rst SHALL take priority over flush and start.

Verification (WIDTH=32)
REQ-029 mult with opr1=FFFFFFFF, opr2=00000002 at cycle N -> done at N+33; hi=FFFFFFFF, lo=FFFFFFFE.
REQ-030 multu with the same operands -> hi=00000001, lo=FFFFFFFE; busy high exactly in cycles N+1..N+32.
REQ-031 div with opr1=FFFFFFF9 (-7), opr2=00000002 -> lo=FFFFFFFD, hi=FFFFFFFF; then divu 0000000A/00000000 started in the DONE cycle -> lo=FFFFFFFF, hi=0000000A, 33 cycles later.
REQ-032 div with opr1=80000000, opr2=FFFFFFFF -> lo=80000000, hi=00000000.
REQ-033 flush at N+10 of a multu -> busy=0 at N+11, no done pulse, hi/lo keep their prior values; a following start completes normally.
REQ-034 rst at N+5 of a div -> at N+6 busy=0, done=0, hi=lo=0, and start in the same cycle as rst is ignored.

Source files
------------

// File: rtl/mdu.sv
// Iterative multiply/divide unit.
// Signed and unsigned multiply use radix-2 shift-add. Signed and unsigned
// divide use restoring division. Both work on operand magnitudes, one step
// per cycle for WIDTH cycles. A final sign fix-up is applied when the
// result is written to hi/lo.
//
// Handshake: start is sampled only in IDLE or DONE. busy is high during
// the WIDTH CALC cycles. done pulses for exactly one cycle, and that cycle
// is the first one in which hi/lo show the new result. hi/lo change only
// on that write, on reset, and never while an operation is running.
// flush drops the operation in flight without writing hi/lo. rst takes
// priority over flush, and flush takes priority over start.
module mdu #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] opr1,
  input  logic [WIDTH-1:0] opr2,
  input  logic             flush,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic [1:0]       dbg_state
);

  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t             state;
  logic [CW-1:0]      cnt;
  logic               op_div;
  logic               neg_res;
  logic               neg_rem;
  logic               div0;
  logic [WIDTH-1:0]   mag_b;
  logic [2*WIDTH-1:0] acc;

  // Values captured when a start is accepted.
  logic             s1;
  logic             s2;
  logic [WIDTH-1:0] m1;
  logic [WIDTH-1:0] m2;

  // One iteration step and the final signed result.
  logic [WIDTH:0]     sum_w;
  logic [WIDTH:0]     rem_sh;
  logic [WIDTH:0]     diff_w;
  logic [2*WIDTH-1:0] acc_step;
  logic [2*WIDTH-1:0] prod_fin;
  logic [WIDTH-1:0]   q_mag;
  logic [WIDTH-1:0]   r_mag;
  logic [WIDTH-1:0]   res_hi;
  logic [WIDTH-1:0]   res_lo;
  logic               last_iter;

  assign dbg_state = state;
  assign last_iter = (cnt == CW'(WIDTH - 1));

  // Operand signs (signed ops only) and magnitudes for an incoming start.
  always_comb begin
    s1 = ~op[0] & opr1[WIDTH-1];
    s2 = ~op[0] & opr2[WIDTH-1];
    m1 = s1 ? -opr1 : opr1;
    m2 = s2 ? -opr2 : opr2;
  end

  // Single shift-add or restoring-divide step applied to the accumulator.
  always_comb begin
    // Multiply: acc = {partial product, remaining multiplier bits}.
    sum_w  = {1'b0, acc[2*WIDTH-1:WIDTH]} + {1'b0, (acc[0] ? mag_b : {WIDTH{1'b0}})};
    // Divide: acc = {partial remainder, remaining dividend / quotient bits}.
    rem_sh = acc[2*WIDTH-1:WIDTH-1];
    diff_w = rem_sh - {1'b0, mag_b};
    if (!op_div) begin
      acc_step = {sum_w, acc[WIDTH-1:1]};
    end else if (!diff_w[WIDTH]) begin
      acc_step = {diff_w[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};
    end else begin
      acc_step = {rem_sh[WIDTH-1:0], acc[WIDTH-2:0], 1'b0};
    end
  end

  // Sign fix-up of the finished magnitudes. A zero divisor forces an
  // all-ones quotient whatever the operand signs. The remainder then
  // equals the dividend magnitude, so restoring its sign gives back opr1.
  always_comb begin
    prod_fin = neg_res ? -acc_step : acc_step;
    q_mag    = acc_step[WIDTH-1:0];
    r_mag    = acc_step[2*WIDTH-1:WIDTH];
    if (!op_div) begin
      res_hi = prod_fin[2*WIDTH-1:WIDTH];
      res_lo = prod_fin[WIDTH-1:0];
    end else begin
      res_hi = neg_rem ? -r_mag : r_mag;
      if (div0) begin
        res_lo = {WIDTH{1'b1}};
      end else begin
        res_lo = neg_res ? -q_mag : q_mag;
      end
    end
  end

  // Control FSM, iteration datapath and result registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      cnt     <= '0;
      op_div  <= 1'b0;
      neg_res <= 1'b0;
      neg_rem <= 1'b0;
      div0    <= 1'b0;
      mag_b   <= '0;
      acc     <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
      hi      <= '0;
      lo      <= '0;
    end else if (flush) begin
      state <= IDLE;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else begin
      case (state)
        IDLE, DONE: begin
          done <= 1'b0;
          if (start) begin
            state   <= CALC;
            busy    <= 1'b1;
            cnt     <= '0;
            op_div  <= op[1];
            neg_res <= s1 ^ s2;
            neg_rem <= s1;
            div0    <= (opr2 == '0);
            if (op[1]) begin
              mag_b <= m2;
              acc   <= {{WIDTH{1'b0}}, m1};
            end else begin
              mag_b <= m1;
              acc   <= {{WIDTH{1'b0}}, m2};
            end
          end else begin
            state <= IDLE;
          end
        end
        CALC: begin
          acc <= acc_step;
          cnt <= cnt + CW'(1);
          if (last_iter) begin
            state <= DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
            hi    <= res_hi;
            lo    <= res_lo;
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
          done  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mdu.sv
// Testbench for mdu at WIDTH=32.
// It runs directed vectors from a table, hand-written sequences for
// back-to-back start, flush, reset and ignored start, and random
// operations checked against an arithmetic reference model.
module tb_mdu;

  localparam int W = 32;
  localparam logic [1:0] OP_MULT = 2'b00, OP_MULTU = 2'b01, OP_DIV = 2'b10, OP_DIVU = 2'b11;
  localparam logic [1:0] ST_IDLE = 2'd0;

  logic         clk;
  logic         rst;
  logic         start;
  logic [1:0]   op;
  logic [W-1:0] opr1;
  logic [W-1:0] opr2;
  logic         flush;
  logic         busy;
  logic         done;
  logic [W-1:0] hi;
  logic [W-1:0] lo;
  logic [1:0]   dbg_state;

  int n_assert = 0;
  int n_fail   = 0;

  mdu #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .start(start), .op(op), .opr1(opr1), .opr2(opr2),
    .flush(flush), .busy(busy), .done(done), .hi(hi), .lo(lo), .dbg_state(dbg_state)
  );

  // Clock and reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string        name;
    logic [1:0]   op;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] ehi;
    logic [W-1:0] elo;
  } vec_t;

  vec_t vecs[8];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_assert++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Reference model: plain integer arithmetic.
  task automatic model(input logic [1:0] o, input logic [W-1:0] a, input logic [W-1:0] b,
                       output logic [W-1:0] ehi, output logic [W-1:0] elo);
    longint      sp;
    logic [63:0] up;
    int          sa;
    int          sb;
    sa = a;
    sb = b;
    case (o)
      OP_MULT: begin
        sp = longint'(sa) * longint'(sb);
        {ehi, elo} = sp;
      end
      OP_MULTU: begin
        up = {32'b0, a} * {32'b0, b};
        {ehi, elo} = up;
      end
      default: begin
        if (b == 0) begin
          elo = '1;
          ehi = a;
        end else if (o == OP_DIV && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
          elo = 32'h8000_0000;
          ehi = 32'h0;
        end else if (o == OP_DIV) begin
          elo = sa / sb;
          ehi = sa % sb;
        end else begin
          elo = a / b;
          ehi = a % b;
        end
      end
    endcase
  endtask

  // Driver: called at a negedge. It issues a start and follows the
  // operation until done, counting busy/done and hi/lo hold violations.
  task automatic run_op(input logic [1:0] o, input logic [W-1:0] a, input logic [W-1:0] b,
                        output int lat, output int busy_bad, output int hold_bad);
    logic [W-1:0] ph;
    logic [W-1:0] pl;
    ph = hi;
    pl = lo;
    start = 1'b1;
    op = o;
    opr1 = a;
    opr2 = b;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    opr1 = $urandom;
    opr2 = $urandom;
    lat = 1;
    busy_bad = 0;
    hold_bad = 0;
    while (!done && lat < 100) begin
      if (!busy) busy_bad++;
      if (hi !== ph || lo !== pl) hold_bad++;
      @(negedge clk);
      lat++;
    end
    if (busy) busy_bad++;
  endtask

  task automatic check_op(input string nm, input logic [1:0] o, input logic [W-1:0] a,
                          input logic [W-1:0] b, input logic [W-1:0] ehi,
                          input logic [W-1:0] elo, input bit idle_after);
    int lat;
    int bb;
    int hb;
    run_op(o, a, b, lat, bb, hb);
    chk({nm, " latency"}, lat, 33);
    chk({nm, " busy/done shape"}, bb, 0);
    chk({nm, " hi/lo hold while busy"}, hb, 0);
    chk({nm, " hi"}, hi, ehi);
    chk({nm, " lo"}, lo, elo);
    if (idle_after) begin
      @(negedge clk);
      chk({nm, " done one cycle"}, {done, busy, dbg_state}, {1'b0, 1'b0, ST_IDLE});
    end
  endtask

  // Counts done pulses over n cycles, starting from a negedge.
  task automatic count_done(input int n, output int pulses);
    pulses = 0;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      if (done) pulses++;
    end
  endtask

  function automatic logic [W-1:0] pick();
    case ($urandom_range(0, 6))
      0: return 32'h0;
      1: return 32'hFFFF_FFFF;
      2: return 32'h8000_0000;
      3: return 32'h1;
      4: return W'($urandom_range(0, 20));
      default: return $urandom;
    endcase
  endfunction

  initial begin
    logic [W-1:0] ph;
    logic [W-1:0] pl;
    logic [W-1:0] ehi;
    logic [W-1:0] elo;
    logic [1:0]   ro;
    logic [W-1:0] ra;
    logic [W-1:0] rb;
    int           pulses;
    int           lat;

    vecs[0] = '{"mult -1*2",      OP_MULT,  32'hFFFF_FFFF, 32'h0000_0002, 32'hFFFF_FFFF, 32'hFFFF_FFFE};
    vecs[1] = '{"multu ffffffff*2", OP_MULTU, 32'hFFFF_FFFF, 32'h0000_0002, 32'h0000_0001, 32'hFFFF_FFFE};
    vecs[2] = '{"div -7/2",       OP_DIV,   32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF, 32'hFFFF_FFFD};
    vecs[3] = '{"div min/-1",     OP_DIV,   32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000};
    vecs[4] = '{"divu 10/0",      OP_DIVU,  32'h0000_000A, 32'h0000_0000, 32'h0000_000A, 32'hFFFF_FFFF};
    vecs[5] = '{"div -5/0",       OP_DIV,   32'hFFFF_FFFB, 32'h0000_0000, 32'hFFFF_FFFB, 32'hFFFF_FFFF};
    vecs[6] = '{"mult min*min",   OP_MULT,  32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000};
    vecs[7] = '{"divu 100/7",     OP_DIVU,  32'h0000_0064, 32'h0000_0007, 32'h0000_0002, 32'h0000_000E};

    rst = 1'b1;
    start = 1'b0;
    flush = 1'b0;
    op = 2'b00;
    opr1 = '0;
    opr2 = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("reset state", {busy, done, dbg_state, hi, lo}, {1'b0, 1'b0, ST_IDLE, 64'h0});
    rst = 1'b0;

    // Directed table
    for (int i = 0; i < 8; i++) begin
      check_op(vecs[i].name, vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].ehi, vecs[i].elo, 1'b1);
    end

    // Back-to-back: the second start is issued in the DONE cycle of the first
    check_op("b2b div -7/2", OP_DIV, 32'hFFFF_FFF9, 32'h2, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0);
    check_op("b2b divu 10/0", OP_DIVU, 32'hA, 32'h0, 32'hA, 32'hFFFF_FFFF, 1'b1);

    // Flush at N+10 of a multu
    check_op("pre-flush mult", OP_MULTU, 32'h1234, 32'h10, 32'h0, 32'h12340, 1'b1);
    ph = hi;
    pl = lo;
    start = 1'b1;
    op = OP_MULTU;
    opr1 = 32'hFFFF_FFFF;
    opr2 = 32'hFFFF_FFFF;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    repeat (9) @(negedge clk);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    chk("flush busy/done/state", {busy, done, dbg_state}, {1'b0, 1'b0, ST_IDLE});
    chk("flush hi/lo kept", {hi, lo}, {ph, pl});
    count_done(40, pulses);
    chk("flush no done", pulses, 0);
    chk("flush hi/lo still kept", {hi, lo}, {ph, pl});
    check_op("after flush mult", OP_MULT, 32'hFFFF_FFFD, 32'h7, 32'hFFFF_FFFF, 32'hFFFF_FFEB, 1'b1);

    // flush and start together: start dropped
    flush = 1'b1;
    start = 1'b1;
    op = OP_DIVU;
    opr1 = 32'h99;
    opr2 = 32'h3;
    @(negedge clk);
    flush = 1'b0;
    start = 1'b0;
    chk("flush+start dropped", {busy, dbg_state}, {1'b0, ST_IDLE});
    count_done(40, pulses);
    chk("flush+start no done", pulses, 0);

    // start during CALC is ignored with no queuing
    start = 1'b1;
    op = OP_DIVU;
    opr1 = 32'd1000;
    opr2 = 32'd3;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    repeat (2) @(negedge clk);
    start = 1'b1;
    op = OP_MULTU;
    opr1 = 32'd5;
    opr2 = 32'd5;
    @(negedge clk);
    start = 1'b0;
    lat = 4;
    while (!done && lat < 100) begin
      @(negedge clk);
      lat++;
    end
    chk("calc start ignored latency", lat, 33);
    chk("calc start ignored result", {hi, lo}, {32'd1, 32'd333});
    count_done(40, pulses);
    chk("calc start not queued", pulses, 0);

    // Reset at N+5 of a div, with a start in the same cycle
    check_op("pre-reset multu", OP_MULTU, 32'hFFFF_FFFF, 32'h3, 32'h2, 32'hFFFF_FFFD, 1'b1);
    start = 1'b1;
    op = OP_DIV;
    opr1 = 32'hFFFF_0000;
    opr2 = 32'h3;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(negedge clk);
    rst = 1'b1;
    start = 1'b1;
    op = OP_MULTU;
    opr1 = 32'h7;
    opr2 = 32'h9;
    @(negedge clk);
    rst = 1'b0;
    start = 1'b0;
    chk("mid-op reset", {busy, done, dbg_state, hi, lo}, {1'b0, 1'b0, ST_IDLE, 64'h0});
    count_done(40, pulses);
    chk("reset start ignored", {pulses[7:0], busy}, {8'd0, 1'b0});

    // Random operations against the model
    for (int i = 0; i < 60; i++) begin
      ro = 2'($urandom_range(0, 3));
      ra = pick();
      rb = pick();
      model(ro, ra, rb, ehi, elo);
      check_op($sformatf("rand%0d op%0d %h,%h", i, ro, ra, rb), ro, ra, rb, ehi, elo,
               1'($urandom_range(0, 1)));
    end

    @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
